uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Frame-level sequencing FSM for the UART receiver. It owns the oversampling edge counter and the bit counter, and it pulses the enables for the start, data-sample/deserialize, parity and stop checkers. It collects their error flags and issues a one-cycle data_valid per good frame. It sits between the prescaled clock domain front end and the checker/deserializer leaves.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal range 5..9)
PRESC_W, 6, width of prescale input and edge counter

Ports:
clk_based_on_prescale  input  1  oversampling clock
asy_reset  input  1  async active-low reset
rx_in  input  1  serial line, idle high
prescale  input  PRESC_W  oversample ratio (legal: even, 4..2^PRESC_W-2)
par_en  input  1  frame carries a parity bit
start_glitch  input  1  from start checker, valid at edge_cnt==prescale-1 of START
parity_error  input  1  from parity checker, registered, valid one cycle after its enable
stop_error  input  1  from stop checker, registered, valid one cycle after its enable
edge_cnt  output  PRESC_W  position within current bit, 0..prescale-1
bit_cnt  output  4  current bit index in frame (0=start)
data_sample_en  output  1  sampler active (all non-IDLE states)
deser_en  output  1  shift pulse for the deserializer
start_check_enable  output  1  one-cycle pulse
parity_check_enable  output  1  one-cycle pulse
stop_check_enable  output  1  one-cycle pulse
data_valid  output  1  one-cycle pulse, frame accepted
frame_error  output  1  one-cycle pulse, frame dropped

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched prescale 8.
- prescale is latched on IDLE->START and held for the whole frame. Mid-frame changes are ignored.
- edge_cnt increments every cycle outside IDLE/DONE. It wraps prescale-1 -> 0 and bit_cnt increments on each wrap.
- Check point CP = edge_cnt==prescale-2. Decision point DP = edge_cnt==prescale-1. Each enable pulses exactly one cycle at CP of its bit, so the registered checker error is valid at DP.
- IDLE: when rx_in==0, go to START with edge_cnt=0 and bit_cnt=0.
- START: start_check_enable at CP. At DP: if start_glitch, go to IDLE with no frame_error; otherwise go to DATA.
- DATA: deser_en at CP of each data bit. At DP of bit DATA_WIDTH, go to PARITY if par_en, else STOP.
- PARITY: parity_check_enable at CP. At DP, latch parity_error into err_l and go to STOP. The frame is not aborted.
- STOP: stop_check_enable at CP. At DP, latch stop_error into err_l and go to DONE.
- DONE (1 cycle): data_valid = ~err_l, frame_error = err_l. Clear err_l. Counters reset to 0. If rx_in==0, go to START (back-to-back frame); otherwise go to IDLE.
- data_valid and frame_error are never high together. Each fires exactly once per completed frame.
- par_en is sampled at the DATA->PARITY/STOP decision only.
- A parity error and a stop error in the same frame produce a single frame_error pulse.
- Async reset mid-frame returns to IDLE immediately with all enables low. No data_valid is issued.
- prescale values <4 are treated as 4. Odd values are rounded down.

Optional Feature:
UART_RX_ERR_STATUS_EN
- Defined: adds outputs par_err_sticky, stop_err_sticky (1b each) and err_cnt (8b, saturating at 255).
  - Sticky flags set on the latched checker error; err_cnt increments on each frame_error.
  - All three clear on input err_clr (1b); set wins over clear in the same cycle.
  - All reset to 0.
- Undefined: these ports and the err_clr input are absent. Core behaviour is identical.

Decomposition:
- Package uart_rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP, DONE), MIN_PRESCALE=4, BIT_CNT_W=4.
- One natural sub-module, uart_rx_edge_bit_counter: owns edge_cnt/bit_cnt, prescale latch/clamp, and the CP/DP strobes. The FSM consumes only the strobes.

Test Plan:
- prescale=8, par_en=0, frame 0xA5 with good stop -> deser_en pulses 8 times at edge_cnt 6; stop_check_enable at bit 9 edge 6; data_valid=1 for one cycle in DONE; frame_error=0.
- prescale=16, par_en=1, parity_error=1 on the cycle after parity_check_enable -> stop still checked; frame_error=1 once; data_valid=0.
- rx_in low for 3 cycles then high, start_glitch=1 at edge 7 (prescale=8) -> return to IDLE; no deser_en, data_valid or frame_error.
- Two back-to-back frames with rx_in=0 during DONE -> START entered the next cycle; two data_valid pulses exactly 8*(1+8+1)+1 cycles apart.
- asy_reset asserted at DATA bit 4 -> all outputs 0 immediately; after release, IDLE waits for a new falling edge; no stale data_valid.
- prescale changed 8->32 mid-frame -> current frame timing stays at 8; next frame uses 32.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the UART receive frame controller.
//   rx_state_e        frame sequencing states
//   MIN_PRESCALE      smallest oversample ratio the counters will run with
//   DEFAULT_PRESCALE  oversample ratio held in the latch out of reset
//   BIT_CNT_W         width of the in-frame bit index
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_e;

    localparam int MIN_PRESCALE     = 4;
    localparam int DEFAULT_PRESCALE = 8;
    localparam int BIT_CNT_W        = 4;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// ---------------------------------------------------------------------------
// uart_rx_edge_bit_counter
// Oversampling edge counter and bit counter for the UART receive controller.
// The prescale value is cleaned up (odd -> even, below minimum -> minimum)
// and latched at the start of each frame so mid-frame changes are ignored.
//
// Ports
//   clk_based_on_prescale  in   oversampling clock
//   asy_reset              in   async active-low reset
//   prescale               in   requested oversample ratio
//   start_frame            in   a new frame starts next cycle: latch prescale,
//                               zero both counters
//   run                    in   advance edge_cnt this cycle
//   clear                  in   zero both counters (frame end / abort)
//   edge_cnt               out  position within the current bit
//   bit_cnt                out  bit index within the frame (0 = start bit)
//   cp_pre                 out  strobe: next cycle is the check point
//   dp                     out  strobe: this cycle is the decision point
// ---------------------------------------------------------------------------
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic                 clk_based_on_prescale,
    input  logic                 asy_reset,
    input  logic [PRESC_W-1:0]   prescale,
    input  logic                 start_frame,
    input  logic                 run,
    input  logic                 clear,
    output logic [PRESC_W-1:0]   edge_cnt,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 cp_pre,
    output logic                 dp
);

    logic [PRESC_W-1:0] presc_l;
    logic [PRESC_W-1:0] presc_even;
    logic [PRESC_W-1:0] presc_clamped;

    // Masking bit 0 rounds odd ratios down to the next even value.
    assign presc_even    = prescale & ~PRESC_W'(1);
    assign presc_clamped = (presc_even < PRESC_W'(MIN_PRESCALE)) ?
                           PRESC_W'(MIN_PRESCALE) : presc_even;

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            presc_l  <= PRESC_W'(DEFAULT_PRESCALE);
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (start_frame) begin
            presc_l  <= presc_clamped;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clear) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (run) begin
            if (edge_cnt == presc_l - PRESC_W'(1)) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            end else begin
                edge_cnt <= edge_cnt + PRESC_W'(1);
            end
        end
    end

    // The check-point strobe fires one cycle early so that the FSM's
    // registered enables land exactly on edge_cnt == prescale-2.
    assign cp_pre = run && (edge_cnt == presc_l - PRESC_W'(3));
    assign dp     = run && (edge_cnt == presc_l - PRESC_W'(1));

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Frame-level sequencer for the UART receiver. Walks START/DATA/PARITY/STOP,
// pulses the checker and deserializer enables at each bit's check point,
// gathers checker errors and reports one data_valid or frame_error per frame.
//
// Optional build macro: UART_RX_ERR_STATUS_EN adds sticky error flags and a
// saturating frame-error counter, cleared by err_clr.
//
// Ports
//   clk_based_on_prescale  in   oversampling clock
//   asy_reset              in   async active-low reset
//   rx_in                  in   serial line, idle high
//   prescale               in   oversample ratio
//   par_en                 in   frame carries a parity bit
//   start_glitch           in   start checker result, valid at DP of START
//   parity_error           in   parity checker result, valid at DP
//   stop_error             in   stop checker result, valid at DP
//   edge_cnt               out  position within current bit
//   bit_cnt                out  bit index within frame (0 = start)
//   data_sample_en         out  sampler active outside IDLE
//   deser_en               out  deserializer shift pulse
//   start_check_enable     out  start checker pulse
//   parity_check_enable    out  parity checker pulse
//   stop_check_enable      out  stop checker pulse
//   data_valid             out  frame accepted pulse
//   frame_error            out  frame dropped pulse
//   err_clr                in   (macro only) clear error status
//   par_err_sticky         out  (macro only) parity error seen
//   stop_err_sticky        out  (macro only) stop error seen
//   err_cnt                out  (macro only) saturating frame-error count
// ---------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                 clk_based_on_prescale,
    input  logic                 asy_reset,
    input  logic                 rx_in,
    input  logic [PRESC_W-1:0]   prescale,
    input  logic                 par_en,
    input  logic                 start_glitch,
    input  logic                 parity_error,
    input  logic                 stop_error,
    output logic [PRESC_W-1:0]   edge_cnt,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 data_sample_en,
    output logic                 deser_en,
    output logic                 start_check_enable,
    output logic                 parity_check_enable,
    output logic                 stop_check_enable,
    output logic                 data_valid,
    output logic                 frame_error
`ifdef UART_RX_ERR_STATUS_EN
    ,
    input  logic                 err_clr,
    output logic                 par_err_sticky,
    output logic                 stop_err_sticky,
    output logic [7:0]           err_cnt
`endif
);

    rx_state_e state;
    logic      err_l;
    logic      start_frame;
    logic      run;
    logic      clear;
    logic      cp_pre;
    logic      dp;

    // A frame begins on a low line either from IDLE or straight out of DONE.
    assign start_frame = ((state == IDLE) || (state == DONE)) && !rx_in;
    assign run         = state inside {START, DATA, PARITY, STOP};
    assign clear       = dp && ((state == STOP) ||
                                ((state == START) && start_glitch));

    uart_rx_edge_bit_counter #(
        .PRESC_W (PRESC_W)
    ) u_counter (
        .clk_based_on_prescale (clk_based_on_prescale),
        .asy_reset             (asy_reset),
        .prescale              (prescale),
        .start_frame           (start_frame),
        .run                   (run),
        .clear                 (clear),
        .edge_cnt              (edge_cnt),
        .bit_cnt               (bit_cnt),
        .cp_pre                (cp_pre),
        .dp                    (dp)
    );

    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            state               <= IDLE;
            err_l               <= 1'b0;
            data_sample_en      <= 1'b0;
            deser_en            <= 1'b0;
            start_check_enable  <= 1'b0;
            parity_check_enable <= 1'b0;
            stop_check_enable   <= 1'b0;
            data_valid          <= 1'b0;
            frame_error         <= 1'b0;
        end else begin
            deser_en            <= 1'b0;
            start_check_enable  <= 1'b0;
            parity_check_enable <= 1'b0;
            stop_check_enable   <= 1'b0;
            data_valid          <= 1'b0;
            frame_error         <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_in) begin
                        state          <= START;
                        data_sample_en <= 1'b1;
                    end
                end
                START: begin
                    if (cp_pre) start_check_enable <= 1'b1;
                    if (dp) begin
                        if (start_glitch) begin
                            state          <= IDLE;
                            data_sample_en <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (cp_pre) deser_en <= 1'b1;
                    if (dp && (bit_cnt == BIT_CNT_W'(DATA_WIDTH))) begin
                        state <= par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (cp_pre) parity_check_enable <= 1'b1;
                    if (dp) begin
                        err_l <= err_l | parity_error;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (cp_pre) stop_check_enable <= 1'b1;
                    // The verdict is registered here so that it is visible
                    // during the single DONE cycle.
                    if (dp) begin
                        err_l       <= err_l | stop_error;
                        data_valid  <= ~(err_l | stop_error);
                        frame_error <= err_l | stop_error;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    err_l <= 1'b0;
                    if (!rx_in) begin
                        state <= START;
                    end else begin
                        state          <= IDLE;
                        data_sample_en <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    data_sample_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_ERR_STATUS_EN
    // Error status: a set in the same cycle as err_clr takes priority.
    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            par_err_sticky  <= 1'b0;
            stop_err_sticky <= 1'b0;
            err_cnt         <= 8'd0;
        end else begin
            if ((state == PARITY) && dp && parity_error) begin
                par_err_sticky <= 1'b1;
            end else if (err_clr) begin
                par_err_sticky <= 1'b0;
            end

            if ((state == STOP) && dp && stop_error) begin
                stop_err_sticky <= 1'b1;
            end else if (err_clr) begin
                stop_err_sticky <= 1'b0;
            end

            if (frame_error) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (err_clr) begin
                err_cnt <= 8'd0;
            end
        end
    end
`endif

endmodule
